seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the Phase 1 combinational 8-bit ALU. It keeps the same 4-bit opcode map and adds registered outputs and a start/busy/done handshake. Multiply (Booth radix-2) and divide (non-restoring) are iterative and produce a double-width HI/LO result. It sits between the register-file read ports and the Z/HI/LO writeback registers of the Phase 2 datapath.

## Interface
- `WIDTH`, 32: operand width. Must be a power of two, ≥ 4. `SW = log2(WIDTH)`.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request. Accepted on a rising edge when `busy` = 0.
- `op`, input, 4: opcode, sampled with `start`.
- `a`, `b`, input, WIDTH: operands, sampled with `start`. Two's complement where signed.
- `busy`, output, 1: iterative operation in progress.
- `done`, output, 1: one-cycle pulse. Results are valid from this cycle until the next accept.
- `result_lo`, output, WIDTH: main result, product low half, or quotient.
- `result_hi`, output, WIDTH: product high half or remainder. 0 for all other ops.
- `div_by_zero`, output, 1: set with `done` for DIV with `b` = 0. Cleared at the next accept.

## Operation
- Opcodes:
  - 0 OR, 1 AND, 2 NOT a, 3 ADD, 4 SUB (a−b), 5 NEG (−a).
  - 6 MUL (signed), 7 DIV (signed).
  - 8 SHL, 9 SHR (logical), 10 SHRA (arithmetic), 11 ROL, 12 ROR.
  - 13–15 behave as AND.
- Shift and rotate amount is `b[SW-1:0]`. Upper bits of `b` are ignored.
- ADD, SUB and NEG wrap modulo 2^WIDTH. No carry or overflow output.
- States:
  - IDLE: wait for `start`. Single-cycle ops, and DIV with `b` = 0, compute and register here and stay in IDLE.
  - MUL: runs WIDTH Booth steps on {hi, lo, q−1}, then goes to IDLE.
  - DIV: runs WIDTH non-restoring steps, then goes to DFIX.
  - DFIX: restores the remainder and applies sign correction, then goes to IDLE.
- MUL gives the exact signed 2·WIDTH product, split as {result_hi, result_lo}.
- DIV truncates toward zero. Remainder takes the sign of `a`.
  - Most-negative ÷ −1 gives quotient = most-negative (wraps) and remainder 0.
- DIV with `b` = 0: `result_lo` = all ones, `result_hi` = `a`, `div_by_zero` = 1.
- `start` while `busy` = 1 is ignored. Operands and outputs are unaffected.
- Outputs hold their last values between `done` and the next accept.

## Timing
- Convention: `start` is high in cycle C with `busy` = 0, so it is accepted at the end of C. `done` is high in cycle C+L.
- Latency L:
  - Single-cycle ops: L = 1.
  - DIV with `b` = 0: L = 1.
  - MUL: L = WIDTH+1.
  - DIV: L = WIDTH+2.
- `busy` is high in cycles C+1 … C+L−1. It never rises for L = 1.
- `busy` is low in the `done` cycle, so back-to-back `start` is accepted in that cycle.
- On reset, all outputs go to 0, state goes to IDLE, and the step counter clears.
  - Reset mid-operation aborts with no `done`.
  - The first accept after `rst_n` rises behaves normally.
- The step counter is SW+1 bits wide. It loads 0 on accept and the exit compare is against WIDTH−1. There is no wrap-around beyond that.

## Structure
- Package `alu_pkg` holds:
  - opcode constants `OP_OR` … `OP_ROR`;
  - state enum `alu_state_t` (IDLE, MUL, DIV, DFIX).
- Sub-module `seq_muldiv` holds the Booth/non-restoring iterative engine: registers, counter, DFIX correction.
- Top-level `seq_alu` holds the combinational single-cycle ops, the FSM handshake and the output registers.

## Test plan
- WIDTH=8, MUL a=0xFD (−3), b=0x05 → done at C+9: hi=0xFF, lo=0xF1. `busy` high C+1..C+8.
- WIDTH=8, DIV a=0xF9 (−7), b=0x02 → done at C+10: lo=0xFD, hi=0xFF, div_by_zero=0.
- WIDTH=8, DIV a=0x12, b=0x00 → done at C+1: lo=0xFF, hi=0x12, div_by_zero=1. `busy` never high.
- WIDTH=8 single-cycle ops, each done at C+1 with hi=0:
  - SHRA a=0x80, b=0x03 → lo=0xF0.
  - ROR a=0x81, b=0x09 → lo=0xC0 (amount 1).
  - Op 14, a=0x3C, b=0x0F → lo=0x0C.
- WIDTH=32, MUL a=0x0000_1000, b=0x0010_0000 → at C+33: hi=0x1, lo=0x0. A `start` at C+5 with op=ADD is ignored.
- WIDTH=32, `rst_n` pulsed low at C+10 of a DIV → all outputs 0 immediately, no `done`. A next ADD 7+8 gives lo=15 at C'+1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential ALU slice:
//   - 4-bit opcode map (unchanged from the combinational predecessor)
//   - controller state encoding used by seq_alu
package alu_pkg;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SHRA = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  // IDLE : waiting for start, single-cycle ops complete here
  // MUL  : Booth iterations
  // DIV  : non-restoring iterations
  // DFIX : remainder restore + sign correction
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DFIX = 2'd3
  } alu_state_t;

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv
//   Iterative multiply/divide engine. One Booth radix-2 step or one
//   non-restoring division step per clock. The sequencing (which step to
//   run, when to stop) comes from the controller in seq_alu; this block
//   owns the working registers, the step counter and the final divide
//   correction.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   load_mul, load_div  : load operands for a multiply / divide
//   step_mul, step_div  : perform one iteration this cycle
//   a, b                : operands (two's complement), used on load
//   last                : the current step is the final one
//   mul_hi, mul_lo      : product after the step being performed now
//   div_quo, div_rem    : corrected quotient/remainder from the final
//                         iteration registers (valid in the fix cycle)
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_mul,
  input  logic             load_div,
  input  logic             step_mul,
  input  logic             step_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] mul_hi,
  output logic [WIDTH-1:0] mul_lo,
  output logic [WIDTH-1:0] div_quo,
  output logic [WIDTH-1:0] div_rem
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] LAST_CNT = (SW+1)'(WIDTH - 1);

  // The accumulator is one bit wider than the operands: Booth needs the
  // headroom when the multiplicand is the most-negative value, and the
  // non-restoring partial remainder is a signed value in [-2D, 2D).
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH:0]   mcand_reg;   // multiplicand (sign-extended) or divisor magnitude
  logic [WIDTH-1:0] qr_reg;      // multiplier shifting out / quotient shifting in
  logic             q_m1_reg;    // Booth q(-1)
  logic             neg_q_reg;   // quotient must be negated at the end
  logic             neg_r_reg;   // remainder must be negated at the end
  logic [SW:0]      cnt_reg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc_next;
  logic [WIDTH-1:0] booth_q_next;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_acc_next;
  logic [WIDTH-1:0] div_q_next;

  logic [WIDTH-1:0] rem_restored;

  // Magnitudes; the most-negative value maps onto itself, which read as
  // unsigned is exactly 2^(WIDTH-1), the correct magnitude.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Booth radix-2: inspect {q0, q-1}, add/sub multiplicand, then shift
  // {acc, qr, q-1} right arithmetically by one.
  always_comb begin
    booth_sum = acc_reg;
    case ({qr_reg[0], q_m1_reg})
      2'b01:   booth_sum = acc_reg + mcand_reg;
      2'b10:   booth_sum = acc_reg - mcand_reg;
      default: booth_sum = acc_reg;
    endcase
  end

  assign booth_acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_q_next   = {booth_sum[0], qr_reg[WIDTH-1:1]};

  // Non-restoring: shift the next dividend bit in, subtract when the
  // partial remainder is non-negative, add when negative. The quotient bit
  // is 1 whenever the new partial remainder is non-negative.
  assign div_shift    = {acc_reg[WIDTH-1:0], qr_reg[WIDTH-1]};
  assign div_acc_next = acc_reg[WIDTH] ? (div_shift + mcand_reg)
                                       : (div_shift - mcand_reg);
  assign div_q_next   = {qr_reg[WIDTH-2:0], ~div_acc_next[WIDTH]};

  // A negative final partial remainder needs one restoring add. The
  // restored value lies in [0, D) so the low WIDTH bits are sufficient.
  assign rem_restored = acc_reg[WIDTH] ? (acc_reg[WIDTH-1:0] + mcand_reg[WIDTH-1:0])
                                       : acc_reg[WIDTH-1:0];

  assign div_quo = neg_q_reg ? -qr_reg : qr_reg;
  assign div_rem = neg_r_reg ? -rem_restored : rem_restored;

  assign mul_hi = booth_acc_next[WIDTH-1:0];
  assign mul_lo = booth_q_next;

  assign last = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      qr_reg    <= '0;
      q_m1_reg  <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (load_mul) begin
      acc_reg   <= '0;
      mcand_reg <= {a[WIDTH-1], a};
      qr_reg    <= b;
      q_m1_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else if (load_div) begin
      acc_reg   <= '0;
      mcand_reg <= {1'b0, b_mag};
      qr_reg    <= a_mag;
      q_m1_reg  <= 1'b0;
      neg_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r_reg <= a[WIDTH-1];
      cnt_reg   <= '0;
    end else if (step_mul) begin
      acc_reg   <= booth_acc_next;
      qr_reg    <= booth_q_next;
      q_m1_reg  <= qr_reg[0];
      cnt_reg   <= cnt_reg + 1'b1;
    end else if (step_div) begin
      acc_reg   <= div_acc_next;
      qr_reg    <= div_q_next;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu
//   Multi-cycle ALU with a start/busy/done handshake. Logic, add/sub,
//   shift and rotate ops finish in one cycle; signed MUL and DIV run on the
//   iterative engine in seq_muldiv and return a double-width HI/LO result.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, accepted on a rising edge while busy is low
//   op           : 4-bit opcode, sampled with start
//   a, b         : operands, sampled with start
//   busy         : an iterative operation is in progress
//   done         : one-cycle pulse, results valid until the next accept
//   result_lo    : main result / product low half / quotient
//   result_hi    : product high half / remainder, 0 for other ops
//   div_by_zero  : DIV with b = 0, cleared at the next accept
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int SW = $clog2(WIDTH);

  alu_state_t       state;

  logic [SW-1:0]    sh_amt;
  logic [WIDTH-1:0] quick_lo;
  logic             b_zero;
  logic             accept;

  logic             load_mul;
  logic             load_div;
  logic             step_mul;
  logic             step_div;
  logic             last;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  // Only the low SW bits of b form the shift/rotate amount.
  assign sh_amt = b[SW-1:0];
  assign b_zero = (b == '0);
  assign accept = (state == IDLE) && start;

  // Single-cycle results. Opcodes 13-15 (and the iterative opcodes, which
  // never use this path) fall through to AND.
  always_comb begin
    quick_lo = a & b;
    case (op)
      OP_OR:   quick_lo = a | b;
      OP_AND:  quick_lo = a & b;
      OP_NOT:  quick_lo = ~a;
      OP_ADD:  quick_lo = a + b;
      OP_SUB:  quick_lo = a - b;
      OP_NEG:  quick_lo = -a;
      OP_SHL:  quick_lo = a << sh_amt;
      OP_SHR:  quick_lo = a >> sh_amt;
      OP_SHRA: quick_lo = $signed(a) >>> sh_amt;
      // A shift by WIDTH yields zero, so amount 0 degenerates cleanly to a.
      OP_ROL:  quick_lo = (a << sh_amt) | (a >> (WIDTH - int'(sh_amt)));
      OP_ROR:  quick_lo = (a >> sh_amt) | (a << (WIDTH - int'(sh_amt)));
      default: quick_lo = a & b;
    endcase
  end

  // Engine control follows directly from the controller state.
  assign load_mul = accept && (op == OP_MUL);
  assign load_div = accept && (op == OP_DIV) && !b_zero;
  assign step_mul = (state == MUL);
  assign step_div = (state == DIV);

  seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_mul (load_mul),
    .load_div (load_div),
    .step_mul (step_mul),
    .step_div (step_div),
    .a        (a),
    .b        (b),
    .last     (last),
    .mul_hi   (mul_hi),
    .mul_lo   (mul_lo),
    .div_quo  (div_quo),
    .div_rem  (div_rem)
  );

  // Controller and output registers. start outside IDLE is simply not
  // looked at, so a request while busy leaves everything untouched.
  // Result registers keep their previous contents while an iterative op
  // runs and are overwritten only in the cycle that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (op == OP_MUL) begin
              state <= MUL;
              busy  <= 1'b1;
            end else if (op == OP_DIV) begin
              if (b_zero) begin
                result_lo   <= '1;
                result_hi   <= a;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
              end else begin
                state <= DIV;
                busy  <= 1'b1;
              end
            end else begin
              result_lo <= quick_lo;
              result_hi <= '0;
              done      <= 1'b1;
            end
          end
        end
        MUL: begin
          // The engine exposes the outcome of the step running now, so
          // the product is captured on the same edge as the final step.
          if (last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result_hi <= mul_hi;
            result_lo <= mul_lo;
          end
        end
        DIV: begin
          if (last) begin
            state <= DFIX;
          end
        end
        DFIX: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          result_hi <= div_rem;
          result_lo <= div_quo;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
//   Bench for seq_alu with two instances (WIDTH=8 and WIDTH=32) sharing
//   clock and reset. Directed table vectors, randomized vectors against a
//   plain-arithmetic reference model, an ignored-start check and a
//   mid-operation reset sequence.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  lo8, hi8;

  logic        start32;
  logic [3:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dbz32;
  logic [31:0] lo32, hi32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .op          (op8),
    .a           (a8),
    .b           (b8),
    .busy        (busy8),
    .done        (done8),
    .result_lo   (lo8),
    .result_hi   (hi8),
    .div_by_zero (dbz8)
  );

  seq_alu #(.WIDTH(32)) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start32),
    .op          (op32),
    .a           (a32),
    .b           (b32),
    .busy        (busy32),
    .done        (done32),
    .result_lo   (lo32),
    .result_hi   (hi32),
    .div_by_zero (dbz32)
  );

  typedef struct {
    int          w;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
    int          poke;   // cycle offset of an extra start while busy, 0 = none
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; op32 = op; a32 = a; b32 = b;
    end
  endtask

  task automatic sample(input int w, output logic d, output logic bsy,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output logic z);
    if (w == 8) begin
      d = done8; bsy = busy8; lo = {24'h0, lo8}; hi = {24'h0, hi8}; z = dbz8;
    end else begin
      d = done32; bsy = busy32; lo = lo32; hi = hi32; z = dbz32;
    end
  endtask

  // Reference model: signed arithmetic on 64-bit integers, masked to w.
  task automatic ref_model(input int w, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi,
                           output logic dbz, output int lat);
    longint mask, ua, ub, sa, sb, r, p;
    int s;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua;
    sb = ub;
    if (ua[w-1]) sa = ua - (longint'(1) << w);
    if (ub[w-1]) sb = ub - (longint'(1) << w);
    s = int'(ub % longint'(w));
    r = 0; p = 0; dbz = 1'b0; lat = 1; hi = '0;
    case (op)
      4'd0:  r = ua | ub;
      4'd1:  r = ua & ub;
      4'd2:  r = ~ua;
      4'd3:  r = ua + ub;
      4'd4:  r = ua - ub;
      4'd5:  r = -ua;
      4'd6: begin
        p = sa * sb;
        r = p;
        hi = 32'(((p >>> w) & mask));
        lat = w + 1;
      end
      4'd7: begin
        if (ub == 0) begin
          r = mask; hi = 32'(ua); dbz = 1'b1;
        end else begin
          r = sa / sb;
          hi = 32'(((sa % sb) & mask));
          lat = w + 2;
        end
      end
      4'd8:  r = ua << s;
      4'd9:  r = ua >> s;
      4'd10: r = sa >>> s;
      4'd11: r = (ua << s) | (ua >> (w - s));
      4'd12: r = (ua >> s) | (ua << (w - s));
      default: r = ua & ub;
    endcase
    lo = 32'(r & mask);
  endtask

  // Issue one transaction. Called just after a negedge with the target
  // instance able to accept (idle or in its done cycle); returns at the
  // negedge of the done cycle.
  task automatic run(input vec_t v);
    logic d, bsy, z, seen, busy_ok;
    logic [31:0] lo, hi, got_lo, got_hi;
    logic got_z;
    int k;
    seen = 1'b0; busy_ok = 1'b1; k = 0;
    got_lo = '0; got_hi = '0; got_z = 1'b0;
    drive(v.w, 1'b1, v.op, v.a, v.b);
    @(posedge clk);
    #1;
    // Scramble operands after the accept to prove they were captured.
    drive(v.w, 1'b0, OP_ADD, ~v.a, ~v.b);
    while (!seen && k < v.lat + 4) begin
      k++;
      @(negedge clk);
      sample(v.w, d, bsy, lo, hi, z);
      if (bsy != (k < v.lat)) busy_ok = 1'b0;
      if (d) begin
        seen = 1'b1; got_lo = lo; got_hi = hi; got_z = z;
      end
      if (v.poke != 0 && k == v.poke)     drive(v.w, 1'b1, OP_ADD, 32'h1, 32'h2);
      if (v.poke != 0 && k == v.poke + 1) drive(v.w, 1'b0, OP_ADD, 32'h1, 32'h2);
    end
    if (v.poke != 0) drive(v.w, 1'b0, OP_ADD, 32'h0, 32'h0);
    check("latency", seen ? k : -1, v.lat);
    check("busy_profile", busy_ok, 1);
    if (seen) begin
      check("result_lo", got_lo, v.lo);
      check("result_hi", got_hi, v.hi);
      check("div_by_zero", got_z, v.dbz);
    end
    $display("txn w=%0d op=%0d a=%h b=%h -> lo=%h hi=%h dbz=%0d lat=%0d",
             v.w, v.op, v.a, v.b, got_lo, got_hi, got_z, seen ? k : -1);
  endtask

  vec_t vecs[12];

  initial begin
    vec_t v;
    logic d, bsy, z;
    logic [31:0] lo, hi;
    int ndone;

    vecs[0]  = '{8,  OP_MUL,  32'hFD,       32'h05,     32'hF1,       32'hFF,       1'b0, 9,  0};
    vecs[1]  = '{8,  OP_DIV,  32'hF9,       32'h02,     32'hFD,       32'hFF,       1'b0, 10, 0};
    vecs[2]  = '{8,  OP_DIV,  32'h12,       32'h00,     32'hFF,       32'h12,       1'b1, 1,  0};
    vecs[3]  = '{8,  OP_SHRA, 32'h80,       32'h03,     32'hF0,       32'h00,       1'b0, 1,  0};
    vecs[4]  = '{8,  OP_ROR,  32'h81,       32'h09,     32'hC0,       32'h00,       1'b0, 1,  0};
    vecs[5]  = '{8,  4'd14,   32'h3C,       32'h0F,     32'h0C,       32'h00,       1'b0, 1,  0};
    vecs[6]  = '{32, OP_MUL,  32'h0000_1000, 32'h0010_0000, 32'h0,    32'h1,        1'b0, 33, 5};
    vecs[7]  = '{8,  OP_DIV,  32'h80,       32'hFF,     32'h80,       32'h00,       1'b0, 10, 0};
    vecs[8]  = '{8,  OP_ADD,  32'hFF,       32'h02,     32'h01,       32'h00,       1'b0, 1,  0};
    vecs[9]  = '{32, OP_DIV,  32'hFFFF_FFF9, 32'h2,     32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0};
    vecs[10] = '{8,  OP_DIV,  32'h07,       32'hFE,     32'hFD,       32'h01,       1'b0, 10, 0};
    vecs[11] = '{32, OP_SUB,  32'h5,        32'h7,      32'hFFFF_FFFE, 32'h0,       1'b0, 1,  0};

    drive(8, 1'b0, 4'd0, 32'h0, 32'h0);
    drive(32, 1'b0, 4'd0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    sample(8, d, bsy, lo, hi, z);
    check("rst8_busy", bsy, 0); check("rst8_done", d, 0);
    check("rst8_lo", lo, 0);    check("rst8_hi", hi, 0); check("rst8_dbz", z, 0);
    sample(32, d, bsy, lo, hi, z);
    check("rst32_busy", bsy, 0); check("rst32_done", d, 0);
    check("rst32_lo", lo, 0);    check("rst32_hi", hi, 0); check("rst32_dbz", z, 0);

    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 12; i++) run(vecs[i]);

    // Randomized vectors against the reference model.
    for (int i = 0; i < 60; i++) begin
      v.w = (i % 2 == 0) ? 8 : 32;
      v.op = 4'($urandom_range(0, 15));
      v.a = $urandom;
      v.b = $urandom;
      if ($urandom_range(0, 5) == 0) v.b = 32'h0;
      if ($urandom_range(0, 7) == 0) v.a = 32'h1 << (v.w - 1);
      if ($urandom_range(0, 7) == 0) v.b = 32'hFFFF_FFFF;
      if (v.w == 8) begin
        v.a = v.a & 32'hFF;
        v.b = v.b & 32'hFF;
      end
      v.poke = 0;
      ref_model(v.w, v.op, v.a, v.b, v.lo, v.hi, v.dbz, v.lat);
      run(v);
    end

    // Known non-zero outputs, then reset in the middle of a long DIV.
    v = '{32, OP_OR, 32'h0000_F0F0, 32'h0, 32'h0000_F0F0, 32'h0, 1'b0, 1, 0};
    run(v);
    drive(32, 1'b1, OP_DIV, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    drive(32, 1'b0, OP_ADD, 32'h0, 32'h0);
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    sample(32, d, bsy, lo, hi, z);
    check("busy_before_reset", bsy, 1);
    rst_n = 1'b0;
    #1;
    sample(32, d, bsy, lo, hi, z);
    check("midrst_busy", bsy, 0); check("midrst_done", d, 0);
    check("midrst_lo", lo, 0);    check("midrst_hi", hi, 0); check("midrst_dbz", z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    v = '{32, OP_ADD, 32'd7, 32'd8, 32'd15, 32'h0, 1'b0, 1, 0};
    run(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
